ddr3_rd_sched: RTL and testbench
================================

DDR3_RD_SCHED -- requirements
Module: ddr3_rd_sched

Interface
REQ-001 SHALL have parameter burst_rd_length, default 20'd128: beats per read burst, driven on rd_len_0.
REQ-002 SHALL have parameter timeout_cycles, default 16'd4096: maximum cycles allowed in DATA before the burst is aborted.
REQ-003 SHALL have port ddr3_user_clk  in  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ddr3_ui_rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port req  in  3: per-requester read request; bit k belongs to requester k.
REQ-006 SHALL have ports req_addr_0, req_addr_1, req_addr_2  in  32 each: DDR3 start address of each requester.
REQ-007 SHALL have port gnt  out  3: one-hot grant, held high for the whole transaction.
REQ-008 SHALL have port rd_addr_0  out  32: read command address to the DDR3 user port.
REQ-009 SHALL have port rd_len_0  out  20: read length, equal to burst_rd_length.
REQ-010 SHALL have port rd_valid_0  out  1, with rd_ready_0  in  1: read command handshake.
REQ-011 SHALL have ports rd_data_0  in  128, rd_data_valid_0  in  1, rd_data_end_0  in  1: read return data.
REQ-012 SHALL have ports ch_data  out  128, ch_data_valid  out  3, ch_data_end  out  3: return data steered to the granted requester.
REQ-013 SHALL have ports busy  out  1 and err  out  1: busy is high when the FSM is not in IDLE; err is a sticky protocol-error flag.

Function
REQ-014 SHALL implement the FSM states IDLE, CMD and DATA.
REQ-015 IDLE: when any req bit is high, SHALL pick a winner round-robin, searching from pointer+1 mod 3. Next edge: gnt=one-hot(winner), rd_addr_0=req_addr_winner (registered), rd_valid_0=1, state goes to CMD.
REQ-016 CMD: SHALL hold rd_valid_0, rd_addr_0 and gnt stable until an edge where rd_valid_0 && rd_ready_0. On that edge: rd_valid_0=0, beat counter=0, watchdog=0, state goes to DATA.
REQ-017 DATA: each cycle with rd_data_valid_0 SHALL register ch_data<=rd_data_0 and ch_data_valid[winner]<=1, with 1-cycle latency. The beat counter (20 bit) SHALL increment once per valid beat.
REQ-018 DATA: rd_data_end_0 SHALL register ch_data_end[winner]<=1 for one cycle, aligned with its own data beat, when rd_data_valid_0 is high in the same cycle.
REQ-019 On rd_data_end_0, the next edge SHALL: set gnt=0, set pointer=winner, return state to IDLE.
REQ-020 At that end edge, if the beat count including the current beat != burst_rd_length, err SHALL be set to 1.
REQ-021 In DATA the watchdog SHALL increment every cycle. On reaching timeout_cycles-1 without rd_data_end_0, the block SHALL set err=1, drop gnt, and return to IDLE without pulsing ch_data_end.
REQ-022 rd_data_valid_0 or rd_data_end_0 seen in IDLE or CMD SHALL be dropped (not forwarded) and SHALL set err=1.
REQ-023 req SHALL be sampled only in IDLE. Req bits dropping during CMD or DATA SHALL not affect the transaction. A requester whose req falls before its grant is not served.
REQ-024 The block SHALL be IDLE for at least 1 cycle between transactions; back-to-back issue is therefore command, end, idle, command.
REQ-025 ch_data_valid and ch_data_end bits SHALL be zero for requesters that are not granted; ch_data SHALL hold its last value when not valid.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 While ddr3_ui_rst_n=0, the block SHALL asynchronously force: state=IDLE, gnt=0, rd_valid_0=0, rd_addr_0=0, ch_data=0, ch_data_valid=0, ch_data_end=0, busy=0, err=0, pointer=2 (so requester 0 has first priority), counters=0.
REQ-028 Reset asserted mid-transaction SHALL abandon it without any end pulse. After release, the first grant SHALL follow the REQ-015 rules from the reset pointer.
REQ-029 Reset deassertion SHALL be taken synchronously by the design; no output may change on the release edge other than by normal IDLE evaluation.

Verification
REQ-030 Scenario: req=3'b111 after reset, rd_ready_0=1, 128-beat bursts -> gnt order 001, 010, 100, 001; rd_addr_0 matches each req_addr; err=0.
REQ-031 Scenario: rd_ready_0 held low 10 cycles in CMD -> rd_valid_0 stays 1 with rd_addr_0 unchanged for 11 cycles, then drops 1 cycle after the handshake.
REQ-032 Scenario: burst ending after 127 beats -> ch_data_end pulse on the 127th beat, err=1, next grant proceeds normally.
REQ-033 Scenario: no rd_data_end_0 for 4096 cycles in DATA -> gnt=0 and err=1 at cycle 4096, state IDLE, no ch_data_end pulse.
REQ-034 Scenario: reset pulsed at beat 50 of a burst for requester 1 -> all outputs zero immediately; after release, req=3'b011 grants 001 first.
REQ-035 Scenario: stray rd_data_valid_0 while IDLE -> no ch_data_valid, err=1.

Source files
------------

// File: rtl/ddr3_rd_sched.sv
// ddr3_rd_sched
// Round-robin read scheduler that lets three requesters share one DDR3 user
// read port. A winner is picked in IDLE, one read command is issued (CMD),
// and the returned beats are steered to the winner (DATA). The DATA phase is
// guarded by a watchdog, and protocol problems raise a sticky error flag.
//
// Ports
//   ddr3_user_clk, ddr3_ui_rst_n   clock, async active-low reset
//   req[2:0], req_addr_0..2        per-requester request and start address
//   gnt[2:0]                       one-hot grant, held for the whole transaction
//   rd_addr_0, rd_len_0,
//   rd_valid_0 / rd_ready_0        read command to the DDR3 user port
//   rd_data_0, rd_data_valid_0,
//   rd_data_end_0                  read return data from the DDR3 user port
//   ch_data, ch_data_valid[2:0],
//   ch_data_end[2:0]               return data steered to the granted requester
//   busy, err                      not-idle indicator, sticky protocol error
//   dbg_state                      current FSM state (0 IDLE, 1 CMD, 2 DATA)
//
// Handshake: a command transfers on a rising edge where rd_valid_0 and
// rd_ready_0 are both high; while rd_valid_0 is high and rd_ready_0 is low,
// rd_addr_0 and gnt stay stable and rd_valid_0 is never withdrawn.
module ddr3_rd_sched #(
    parameter logic [19:0] burst_rd_length = 20'd128,
    parameter logic [15:0] timeout_cycles  = 16'd4096
) (
    input  logic         ddr3_user_clk,
    input  logic         ddr3_ui_rst_n,
    input  logic [2:0]   req,
    input  logic [31:0]  req_addr_0,
    input  logic [31:0]  req_addr_1,
    input  logic [31:0]  req_addr_2,
    output logic [2:0]   gnt,
    output logic [31:0]  rd_addr_0,
    output logic [19:0]  rd_len_0,
    output logic         rd_valid_0,
    input  logic         rd_ready_0,
    input  logic [127:0] rd_data_0,
    input  logic         rd_data_valid_0,
    input  logic         rd_data_end_0,
    output logic [127:0] ch_data,
    output logic [2:0]   ch_data_valid,
    output logic [2:0]   ch_data_end,
    output logic         busy,
    output logic         err,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   gnt_q, gnt_d;
    logic [31:0]  rd_addr_q, rd_addr_d;
    logic         rd_valid_q, rd_valid_d;
    logic [127:0] ch_data_q, ch_data_d;
    logic [2:0]   ch_valid_q, ch_valid_d;
    logic [2:0]   ch_end_q, ch_end_d;
    logic [19:0]  beat_q, beat_d;
    logic [15:0]  wdog_q, wdog_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   win_q, win_d;
    logic         err_q, err_d;

    logic [1:0]   cand0, cand1, cand2;
    logic [1:0]   pick;
    logic [31:0]  pick_addr;
    logic [19:0]  beats_incl;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin search starting one past the last winner.
    always_comb begin
        cand0 = next_idx(ptr_q);
        cand1 = next_idx(cand0);
        cand2 = next_idx(cand1);
        if (req[cand0])      pick = cand0;
        else if (req[cand1]) pick = cand1;
        else                 pick = cand2;
        case (pick)
            2'd0:    pick_addr = req_addr_0;
            2'd1:    pick_addr = req_addr_1;
            default: pick_addr = req_addr_2;
        endcase
    end

    // Beat count as it will stand once the beat on the current cycle is counted.
    assign beats_incl = beat_q + {19'd0, rd_data_valid_0};

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_valid_q;
        ch_data_d  = ch_data_q;
        ch_valid_d = 3'b000;
        ch_end_d   = 3'b000;
        beat_d     = beat_q;
        wdog_d     = wdog_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                // Return data with no transaction open is dropped and flagged.
                if (rd_data_valid_0 || rd_data_end_0) err_d = 1'b1;
                if (|req) begin
                    win_d      = pick;
                    gnt_d      = 3'b001 << pick;
                    rd_addr_d  = pick_addr;
                    rd_valid_d = 1'b1;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rd_data_valid_0 || rd_data_end_0) err_d = 1'b1;
                if (rd_valid_q && rd_ready_0) begin
                    rd_valid_d = 1'b0;
                    beat_d     = 20'd0;
                    wdog_d     = 16'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                // gnt_q is the one-hot of the winner, so it doubles as the steering mask.
                if (rd_data_valid_0) begin
                    ch_data_d  = rd_data_0;
                    ch_valid_d = gnt_q;
                    beat_d     = beat_q + 20'd1;
                    if (rd_data_end_0) ch_end_d = gnt_q;
                end
                if (rd_data_end_0) begin
                    gnt_d   = 3'b000;
                    ptr_d   = win_q;
                    state_d = ST_IDLE;
                    if (beats_incl != burst_rd_length) err_d = 1'b1;
                end else if (wdog_q == timeout_cycles - 16'd1) begin
                    // Abort: no end pulse. The pointer still advances so a
                    // stuck requester cannot monopolise the port.
                    err_d   = 1'b1;
                    gnt_d   = 3'b000;
                    ptr_d   = win_q;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_user_clk or negedge ddr3_ui_rst_n) begin
        if (!ddr3_ui_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            rd_addr_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            ch_data_q  <= 128'd0;
            ch_valid_q <= 3'b000;
            ch_end_q   <= 3'b000;
            beat_q     <= 20'd0;
            wdog_q     <= 16'd0;
            ptr_q      <= 2'd2;     // requester 0 searched first after reset
            win_q      <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            ch_data_q  <= ch_data_d;
            ch_valid_q <= ch_valid_d;
            ch_end_q   <= ch_end_d;
            beat_q     <= beat_d;
            wdog_q     <= wdog_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            err_q      <= err_d;
        end
    end

    assign gnt           = gnt_q;
    assign rd_addr_0     = rd_addr_q;
    assign rd_len_0      = burst_rd_length;
    assign rd_valid_0    = rd_valid_q;
    assign ch_data       = ch_data_q;
    assign ch_data_valid = ch_valid_q;
    assign ch_data_end   = ch_end_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ddr3_rd_sched.sv
// Bench for ddr3_rd_sched: table of round-robin transactions, then hand-written
// watchdog-abort, mid-burst reset and stray-data sequences. Returned beats are
// checked against an expected queue filled as the beats are driven.
module tb_ddr3_rd_sched;

    localparam int          BURST = 128;
    localparam int          TMO   = 4096;
    localparam logic [31:0] A0    = 32'h1000_0040;
    localparam logic [31:0] A1    = 32'h2000_0080;
    localparam logic [31:0] A2    = 32'h3000_00C0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]   req;
    logic [31:0]  req_addr_0, req_addr_1, req_addr_2;
    logic [2:0]   gnt;
    logic [31:0]  rd_addr_0;
    logic [19:0]  rd_len_0;
    logic         rd_valid_0, rd_ready_0;
    logic [127:0] rd_data_0;
    logic         rd_data_valid_0, rd_data_end_0;
    logic [127:0] ch_data;
    logic [2:0]   ch_data_valid, ch_data_end;
    logic         busy, err;
    logic [1:0]   dbg_state;

    ddr3_rd_sched dut (
        .ddr3_user_clk   (clk),
        .ddr3_ui_rst_n   (rst_n),
        .req             (req),
        .req_addr_0      (req_addr_0),
        .req_addr_1      (req_addr_1),
        .req_addr_2      (req_addr_2),
        .gnt             (gnt),
        .rd_addr_0       (rd_addr_0),
        .rd_len_0        (rd_len_0),
        .rd_valid_0      (rd_valid_0),
        .rd_ready_0      (rd_ready_0),
        .rd_data_0       (rd_data_0),
        .rd_data_valid_0 (rd_data_valid_0),
        .rd_data_end_0   (rd_data_end_0),
        .ch_data         (ch_data),
        .ch_data_valid   (ch_data_valid),
        .ch_data_end     (ch_data_end),
        .busy            (busy),
        .err             (err),
        .dbg_state       (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: {valid mask, end mask, data} per expected output beat.
    logic [133:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && (ch_data_valid != 3'b000 || ch_data_end != 3'b000)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ch_beat", {ch_data_valid, ch_data_end}, 134'd0);
            end else begin
                check("ch_beat", {ch_data_valid, ch_data_end, ch_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT in IDLE: request, grant, then the
    // command handshake after dly cycles of rd_ready_0 low.
    task automatic grant_cmd(input logic [2:0] r, input int dly,
                             input logic [2:0] eg, input logic [31:0] ea);
        req = r;
        @(negedge clk);
        check("gnt", gnt, eg);
        check("rd_valid_at_grant", rd_valid_0, 1);
        check("rd_addr", rd_addr_0, ea);
        check("busy_in_cmd", busy, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("rd_valid_hold", rd_valid_0, 1);
            check("rd_addr_hold", rd_addr_0, ea);
            check("gnt_hold", gnt, eg);
        end
        rd_ready_0 = 1'b1;
        @(negedge clk);
        rd_ready_0 = 1'b0;
        check("rd_valid_drop", rd_valid_0, 0);
        check("state_data", dbg_state, 2);
    endtask

    task automatic send_beats(input int n, input bit with_end, input logic [2:0] g);
        for (int b = 0; b < n; b++) begin
            rd_data_0       = {$urandom, $urandom, $urandom, $urandom};
            rd_data_valid_0 = 1'b1;
            rd_data_end_0   = with_end && (b == n - 1);
            exp_q.push_back({g, (rd_data_end_0 ? g : 3'b000), rd_data_0});
            @(negedge clk);
        end
        rd_data_valid_0 = 1'b0;
        rd_data_end_0   = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req;
        int          dly;
        int          beats;
        logic [2:0]  exp_gnt;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t         tbl[7];
    int           cnt;
    logic [127:0] last_data;

    initial begin
        tbl[0] = '{3'b111, 0,  BURST,     3'b001, A0, 1'b0};
        tbl[1] = '{3'b111, 0,  BURST,     3'b010, A1, 1'b0};
        tbl[2] = '{3'b111, 2,  BURST,     3'b100, A2, 1'b0};
        tbl[3] = '{3'b111, 10, BURST,     3'b001, A0, 1'b0};
        tbl[4] = '{3'b111, 0,  BURST - 1, 3'b010, A1, 1'b1};
        tbl[5] = '{3'b100, 0,  16,        3'b100, A2, 1'b1};
        tbl[6] = '{3'b001, 1,  4,         3'b001, A0, 1'b1};

        rst_n = 1'b0;
        req = 3'b000;
        req_addr_0 = A0; req_addr_1 = A1; req_addr_2 = A2;
        rd_ready_0 = 1'b0;
        rd_data_0 = 128'd0;
        rd_data_valid_0 = 1'b0;
        rd_data_end_0 = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rd_valid", rd_valid_0, 0);
        check("rst_rd_addr", rd_addr_0, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ch_data", ch_data, 0);
        check("rd_len", rd_len_0, BURST);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_idle", dbg_state, 0);

        // Round-robin table; the end-of-burst negedge doubles as the single
        // idle cycle in which the next request is presented.
        for (int i = 0; i < 7; i++) begin
            grant_cmd(tbl[i].req, tbl[i].dly, tbl[i].exp_gnt, tbl[i].exp_addr);
            send_beats(tbl[i].beats, 1'b1, tbl[i].exp_gnt);
            check("gnt_released", gnt, 0);
            check("idle_after_end", busy, 0);
            check("err_after_txn", err, tbl[i].exp_err);
        end

        // Watchdog abort; req drops mid-transaction without effect.
        grant_cmd(3'b010, 0, 3'b010, A1);
        req = 3'b000;
        cnt = 0;
        while (cnt < TMO + 900 && gnt != 3'b000) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", cnt, TMO);
        check("timeout_idle", dbg_state, 0);
        check("timeout_err", err, 1);

        // Reset asserted while the 50th beat for requester 1 is on the bus.
        grant_cmd(3'b010, 0, 3'b010, A1);
        req = 3'b000;
        send_beats(49, 1'b0, 3'b010);
        rd_data_0 = {$urandom, $urandom, $urandom, $urandom};
        rd_data_valid_0 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_gnt", gnt, 0);
        check("arst_rd_addr", rd_addr_0, 0);
        check("arst_ch", {ch_data_valid, ch_data_end, ch_data}, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        rd_data_valid_0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_no_change", {gnt, rd_valid_0, busy}, 0);
        grant_cmd(3'b011, 0, 3'b001, A0);
        send_beats(BURST, 1'b1, 3'b001);
        check("post_reset_err", err, 0);

        // Stray return data in IDLE: dropped, ch_data holds, err set.
        req = 3'b000;
        last_data = rd_data_0;
        rd_data_0 = ~last_data;
        rd_data_valid_0 = 1'b1;
        rd_data_end_0 = 1'b1;
        @(negedge clk);
        rd_data_valid_0 = 1'b0;
        rd_data_end_0 = 1'b0;
        check("stray_no_valid", {ch_data_valid, ch_data_end}, 0);
        check("stray_ch_hold", ch_data, last_data);
        check("stray_err", err, 1);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
